// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline definitions: widths, ALU opcodes and operand-select encodings.
package rv32_pipe_pkg;
    localparam int DATA_W     = 32;
    localparam int ALU_SEL_W  = 4;
    localparam int REG_ADDR_W = 5;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'd2;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'd3;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 4'd4;
    localparam logic [ALU_SEL_W-1:0] ALU_SRA  = 4'd5;
    localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 4'd6;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'd7;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'd8;
    localparam logic [ALU_SEL_W-1:0] ALU_BSEL = 4'd9;

    localparam logic OPA_RS1 = 1'b0;
    localparam logic OPA_PC  = 1'b1;
    localparam logic OPB_RS2 = 1'b0;
    localparam logic OPB_IMM = 1'b1;
endpackage

// File: rtl/fwd_mux.sv
// Per-source operand resolver: x0 / EX / MEM / WB priority forwarding plus match flags.
// ALU_ISSUE_FORWARDING_EN enables the bypass paths; otherwise only x0 is special-cased.
module fwd_mux
    import rv32_pipe_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_ADDR_W
) (
    input  logic [AW-1:0] src_addr_i,
    input  logic [DW-1:0] src_data_i,
    input  logic          ex_valid_i,
    input  logic          ex_rd_we_i,
    input  logic          ex_is_load_i,
    input  logic [AW-1:0] ex_rd_addr_i,
    input  logic [DW-1:0] alu_result_i,
    input  logic [AW-1:0] mem_rd_addr_i,
    input  logic          mem_rd_we_i,
    input  logic [DW-1:0] mem_rd_data_i,
    input  logic [AW-1:0] wb_rd_addr_i,
    input  logic          wb_rd_we_i,
    input  logic [DW-1:0] wb_rd_data_i,
    output logic [DW-1:0] data_o,
    output logic          ex_match_o,
    output logic          load_match_o,
    output logic          mem_match_o,
    output logic          wb_match_o
);
    logic nz;
    logic ex_addr_eq;

    assign nz           = |src_addr_i;
    assign ex_addr_eq   = nz && ex_valid_i && (ex_rd_addr_i == src_addr_i);
    assign ex_match_o   = ex_addr_eq && ex_rd_we_i;
    assign load_match_o = ex_addr_eq && ex_is_load_i;
    assign mem_match_o  = nz && mem_rd_we_i && (mem_rd_addr_i == src_addr_i);
    assign wb_match_o   = nz && wb_rd_we_i && (wb_rd_addr_i == src_addr_i);

`ifdef ALU_ISSUE_FORWARDING_EN
    always_comb begin
        data_o = src_data_i;
        if (!nz)                             data_o = '0;
        else if (ex_match_o && !ex_is_load_i) data_o = alu_result_i;
        else if (mem_match_o)                data_o = mem_rd_data_i;
        else if (wb_match_o)                 data_o = wb_rd_data_i;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{alu_result_i, mem_rd_data_i, wb_rd_data_i};
    assign data_o     = nz ? src_data_i : '0;
`endif
endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX pipeline register with operand forwarding and hazard stall, feeding the RV32 ALU.
// ALU_ISSUE_FORWARDING_EN: bypass from EX/MEM/WB; undefined: stall on any pending writer.
module alu_issue_stage
    import rv32_pipe_pkg::*;
#(
    parameter int DATA_W     = rv32_pipe_pkg::DATA_W,
    parameter int ALU_SEL_W  = rv32_pipe_pkg::ALU_SEL_W,
    parameter int REG_ADDR_W = rv32_pipe_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [DATA_W-1:0]     id_rs1_data,
    input  logic [DATA_W-1:0]     id_rs2_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic                  id_a_sel,
    input  logic                  id_b_sel,
    input  logic [ALU_SEL_W-1:0]  id_alu_sel,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_rd_we,
    input  logic [DATA_W-1:0]     mem_rd_data,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_rd_we,
    input  logic [DATA_W-1:0]     wb_rd_data,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_inp_a,
    output logic [DATA_W-1:0]     ex_inp_b,
    output logic [ALU_SEL_W-1:0]  ex_alu_sel,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_rd_we,
    output logic                  ex_is_load,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic                  hazard_stall
);
    logic                  valid_q,   valid_d;
    logic [DATA_W-1:0]     a_q,       a_d;
    logic [DATA_W-1:0]     b_q,       b_d;
    logic [ALU_SEL_W-1:0]  sel_q,     sel_d;
    logic [REG_ADDR_W-1:0] rd_q,      rd_d;
    logic                  rd_we_q,   rd_we_d;
    logic                  is_load_q, is_load_d;
    logic [DATA_W-1:0]     store_q,   store_d;

    logic [1:0][DATA_W-1:0]     src_data;
    logic [1:0][DATA_W-1:0]     res_data;
    logic [1:0][REG_ADDR_W-1:0] src_addr;
    logic [1:0] ex_m, ld_m, mem_m, wb_m, used;
    logic       ex_advance, accept;

    assign src_addr = {id_rs2_addr, id_rs1_addr};
    assign src_data = {id_rs2_data, id_rs1_data};
    // Stores and branches compare rs2 even when operand B is the immediate.
    assign used[0]  = (id_a_sel == OPA_RS1);
    assign used[1]  = (id_b_sel == OPB_RS2) || !id_rd_we;

    for (genvar s = 0; s < 2; s++) begin : g_src
        fwd_mux #(.DW(DATA_W), .AW(REG_ADDR_W)) u_fwd (
            .src_addr_i   (src_addr[s]),
            .src_data_i   (src_data[s]),
            .ex_valid_i   (valid_q),
            .ex_rd_we_i   (rd_we_q),
            .ex_is_load_i (is_load_q),
            .ex_rd_addr_i (rd_q),
            .alu_result_i (alu_result),
            .mem_rd_addr_i(mem_rd_addr),
            .mem_rd_we_i  (mem_rd_we),
            .mem_rd_data_i(mem_rd_data),
            .wb_rd_addr_i (wb_rd_addr),
            .wb_rd_we_i   (wb_rd_we),
            .wb_rd_data_i (wb_rd_data),
            .data_o       (res_data[s]),
            .ex_match_o   (ex_m[s]),
            .load_match_o (ld_m[s]),
            .mem_match_o  (mem_m[s]),
            .wb_match_o   (wb_m[s])
        );
    end

`ifdef ALU_ISSUE_FORWARDING_EN
    logic unused_match;
    assign unused_match = ^{ex_m, mem_m, wb_m};
    assign hazard_stall = id_valid && |(used & ld_m);
`else
    logic unused_match;
    assign unused_match = ^ld_m;
    assign hazard_stall = id_valid && |(used & (ex_m | mem_m | wb_m));
`endif

    assign ex_advance = !valid_q || ex_ready;
    assign id_ready   = ex_advance && !hazard_stall;
    assign accept     = ex_advance && id_valid && !hazard_stall && !flush;

    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        rd_d      = rd_q;
        rd_we_d   = rd_we_q;
        is_load_d = is_load_q;
        store_d   = store_q;
        if (flush)           valid_d = 1'b0;
        else if (ex_advance) valid_d = accept;
        if (accept) begin
            a_d       = (id_a_sel == OPA_PC)  ? id_pc  : res_data[0];
            b_d       = (id_b_sel == OPB_IMM) ? id_imm : res_data[1];
            sel_d     = id_alu_sel;
            rd_d      = id_rd_addr;
            rd_we_d   = id_rd_we;
            is_load_d = id_is_load;
            store_d   = res_data[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= '0;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            is_load_q <= 1'b0;
            store_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
            is_load_q <= is_load_d;
            store_q   <= store_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_inp_a      = a_q;
    assign ex_inp_b      = b_q;
    assign ex_alu_sel    = sel_q;
    assign ex_rd_addr    = rd_q;
    assign ex_rd_we      = valid_q && rd_we_q;
    assign ex_is_load    = is_load_q;
    assign ex_store_data = store_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; expectations follow ALU_ISSUE_FORWARDING_EN if defined.
module tb_alu_issue_stage;
    import rv32_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_a_sel, id_b_sel, id_rd_we, id_is_load;
    logic [3:0]  id_alu_sel;
    logic [31:0] alu_result, mem_rd_data, wb_rd_data;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_rd_we, wb_rd_we, flush, ex_ready;
    logic        ex_valid, ex_rd_we, ex_is_load, hazard_stall;
    logic [31:0] ex_inp_a, ex_inp_b, ex_store_data;
    logic [3:0]  ex_alu_sel;
    logic [4:0]  ex_rd_addr;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_alu_sel(id_alu_sel),
        .id_rd_we(id_rd_we), .id_is_load(id_is_load), .alu_result(alu_result),
        .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_rd_data(mem_rd_data),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_rd_data(wb_rd_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_inp_a(ex_inp_a), .ex_inp_b(ex_inp_b), .ex_alu_sel(ex_alu_sel),
        .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .ex_store_data(ex_store_data), .hazard_stall(hazard_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic asel, input logic bsel, input logic [3:0] sel,
                         input logic we, input logic ld);
        id_valid = 1'b1; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_a_sel = asel;
        id_b_sel = bsel; id_alu_sel = sel; id_rd_we = we; id_is_load = ld;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_pc = 32'h1000;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_a_sel = 1'b0; id_b_sel = 1'b0; id_alu_sel = '0; id_rd_we = 1'b0; id_is_load = 1'b0;
        alu_result = '0; mem_rd_addr = '0; mem_rd_we = 1'b0; mem_rd_data = '0;
        wb_rd_addr = '0; wb_rd_we = 1'b0; wb_rd_data = '0; flush = 1'b0; ex_ready = 1'b1;

        tick(); tick();
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_inp_a", ex_inp_a, 32'd0);
        check("rst_rd_we", 32'(ex_rd_we), 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD x3 = x1 + x2
        drive(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, OPA_RS1, OPB_RS2, ALU_ADD, 1'b1, 1'b0);
        check("add_stall", 32'(hazard_stall), 32'd0);
        check("add_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("add_valid", 32'(ex_valid), 32'd1);
        check("add_a", ex_inp_a, 32'd5);
        check("add_b", ex_inp_b, 32'd7);
        check("add_sel", 32'(ex_alu_sel), 32'd0);
        check("add_rd", 32'(ex_rd_addr), 32'd3);
        check("add_store", ex_store_data, 32'd7);

        // SUB x4 = x3 - x1 with held ADD x3 producing 12
        alu_result = 32'd12;
        drive(5'd3, 5'd1, 5'd4, 32'd99, 32'd5, 32'd0, OPA_RS1, OPB_RS2, ALU_SUB, 1'b1, 1'b0);
`ifdef ALU_ISSUE_FORWARDING_EN
        check("sub_stall", 32'(hazard_stall), 32'd0);
        tick();
        check("sub_a_fwd", ex_inp_a, 32'd12);
`else
        check("sub_stall", 32'(hazard_stall), 32'd1);
        check("sub_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("sub_bubble", 32'(ex_valid), 32'd0);
        check("sub_stall_clr", 32'(hazard_stall), 32'd0);
        tick();
        check("sub_a_raw", ex_inp_a, 32'd99);
`endif
        check("sub_b", ex_inp_b, 32'd5);
        check("sub_sel", 32'(ex_alu_sel), 32'd8);

        // LW x5, 4(x1)
        drive(5'd1, 5'd0, 5'd5, 32'h100, 32'd0, 32'd4, OPA_RS1, OPB_IMM, ALU_ADD, 1'b1, 1'b1);
        tick();
        check("lw_is_load", 32'(ex_is_load), 32'd1);
        check("lw_a", ex_inp_a, 32'h100);
        check("lw_b", ex_inp_b, 32'd4);

        // ADD x6 = x5 + x2 right behind the load
        drive(5'd5, 5'd2, 5'd6, 32'd0, 32'd7, 32'd0, OPA_RS1, OPB_RS2, ALU_ADD, 1'b1, 1'b0);
        check("lu_stall", 32'(hazard_stall), 32'd1);
        check("lu_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("lu_bubble", 32'(ex_valid), 32'd0);
        mem_rd_addr = 5'd5; mem_rd_we = 1'b1; mem_rd_data = 32'hDEAD; #1;
`ifndef ALU_ISSUE_FORWARDING_EN
        check("lu_mem_stall", 32'(hazard_stall), 32'd1);
        tick();
        mem_rd_we = 1'b0; wb_rd_addr = 5'd5; wb_rd_we = 1'b1; wb_rd_data = 32'hDEAD; #1;
        check("lu_wb_stall", 32'(hazard_stall), 32'd1);
        tick();
        wb_rd_we = 1'b0; id_rs1_data = 32'hDEAD; #1;
`endif
        check("lu_go", 32'(hazard_stall), 32'd0);
        tick();
        check("lu_a", ex_inp_a, 32'hDEAD);
        check("lu_b", ex_inp_b, 32'd7);
        mem_rd_we = 1'b0; wb_rd_we = 1'b0;

        // Backpressure: OR x8 = x9 | 0x22 while downstream is stalled
        ex_ready = 1'b0;
        drive(5'd9, 5'd0, 5'd8, 32'h11, 32'd0, 32'h22, OPA_RS1, OPB_IMM, ALU_OR, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_id_ready", 32'(id_ready), 32'd0);
            tick();
            check("bp_hold_a", ex_inp_a, 32'hDEAD);
            check("bp_hold_sel", 32'(ex_alu_sel), 32'd0);
        end
        ex_ready = 1'b1; #1;
        check("bp_release", 32'(id_ready), 32'd1);
        tick();
        check("bp_a", ex_inp_a, 32'h11);
        check("bp_b", ex_inp_b, 32'h22);
        check("bp_sel", 32'(ex_alu_sel), 32'd2);

        // Flush with downstream stalled and a new instruction presented
        ex_ready = 1'b0; flush = 1'b1;
        drive(5'd1, 5'd2, 5'd10, 32'd1, 32'd2, 32'd0, OPA_RS1, OPB_RS2, ALU_XOR, 1'b1, 1'b0);
        tick();
        flush = 1'b0; ex_ready = 1'b1;
        check("fl_valid", 32'(ex_valid), 32'd0);
        check("fl_rd_we", 32'(ex_rd_we), 32'd0);

        // WB writing x7 while ADD x11 = x7 + x0 issues
        wb_rd_addr = 5'd7; wb_rd_we = 1'b1; wb_rd_data = 32'h77;
        drive(5'd7, 5'd0, 5'd11, 32'h70, 32'h55, 32'd0, OPA_RS1, OPB_RS2, ALU_ADD, 1'b1, 1'b0);
`ifdef ALU_ISSUE_FORWARDING_EN
        check("wb_stall", 32'(hazard_stall), 32'd0);
`else
        check("wb_stall", 32'(hazard_stall), 32'd1);
        tick();
        check("wb_bubble", 32'(ex_valid), 32'd0);
        wb_rd_we = 1'b0; id_rs1_data = 32'h77; #1;
        check("wb_clear", 32'(hazard_stall), 32'd0);
`endif
        tick();
        wb_rd_we = 1'b0;
        check("wb_a", ex_inp_a, 32'h77);
        check("x0_b", ex_inp_b, 32'd0);
        check("wb_valid", 32'(ex_valid), 32'd1);

        // Asynchronous reset between edges
        id_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ex_valid), 32'd0);
        check("arst_a", ex_inp_a, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
